// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and helpers for the decoder select-code scanner.
// The index search honours an optional skip mask (all zeros when SCAN_SKIP_MASK_EN is off).
package decoder_scan_pkg;

    localparam int SEL_W_DEFAULT   = 4;
    localparam int DWELL_W_DEFAULT = 8;
    localparam int N_IDX           = 1 << SEL_W_DEFAULT;

    typedef logic [SEL_W_DEFAULT-1:0] idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic found;
        idx_t idx;
    } idx_res_t;

    // Walk forward from from_idx (wrapping modulo N_IDX) up to and including
    // last_idx; return the first index whose mask bit is clear.
    function automatic idx_res_t next_index(
        input idx_t             from_idx,
        input idx_t             last_idx,
        input logic [N_IDX-1:0] mask
    );
        idx_res_t res;
        idx_t     idx;
        logic     stop;
        // NOTE: blocking assignments here -- this is combinational evaluation;
        // only clocked processes use non-blocking (<=) updates.
        res  = '0;
        idx  = from_idx;
        stop = 1'b0;
        for (int i = 0; i < N_IDX; i++) begin
            if (!stop) begin
                if (!mask[idx]) begin
                    res.found = 1'b1;
                    res.idx   = idx;
                    stop      = 1'b1;
                end else if (idx == last_idx) begin
                    stop = 1'b1;
                end else begin
                    idx = idx + 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan requester (master) and decoder_scan_ctrl (slave).
// Skip_Mask exists only when SCAN_SKIP_MASK_EN is defined.
interface decoder_scan_ctrl_if #(
    parameter int SEL_W   = decoder_scan_pkg::SEL_W_DEFAULT,
    parameter int DWELL_W = decoder_scan_pkg::DWELL_W_DEFAULT
);

    logic               Start;
    logic               Stop;
    logic               Continuous;
    logic [SEL_W-1:0]   First;
    logic [SEL_W-1:0]   Last;
    logic [DWELL_W-1:0] Dwell;
    logic [SEL_W-1:0]   Sel;
    logic               Sel_Valid;
    logic               Step;
    logic               Busy;
    logic               Done;

`ifdef SCAN_SKIP_MASK_EN
    logic [(1 << SEL_W)-1:0] Skip_Mask;

    modport master (
        output Start, Stop, Continuous, First, Last, Dwell, Skip_Mask,
        input  Sel, Sel_Valid, Step, Busy, Done
    );

    modport slave (
        input  Start, Stop, Continuous, First, Last, Dwell, Skip_Mask,
        output Sel, Sel_Valid, Step, Busy, Done
    );
`else
    modport master (
        output Start, Stop, Continuous, First, Last, Dwell,
        input  Sel, Sel_Valid, Step, Busy, Done
    );

    modport slave (
        input  Start, Stop, Continuous, First, Last, Dwell,
        output Sel, Sel_Valid, Step, Busy, Done
    );
`endif

endinterface

// File: rtl/decoder_scan_ctrl_dwell.sv
// Dwell timer: latches the dwell length at scan start and flags the last
// cycle of each index's hold period.
module scan_dwell_timer #(
    parameter int DWELL_W = decoder_scan_pkg::DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    assign expire = (cnt_q == dwell_q);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        if (load) begin
            cnt_d   = '0;
            dwell_d = dwell;
        end else if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Select-code sequencer feeding the 4-to-16 decoder: scans First..Last with a dwell per index.
// Optional macro SCAN_SKIP_MASK_EN adds a per-index skip mask latched at Start.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic                Clk,
    input  logic                Rst_n,
    decoder_scan_ctrl_if.slave  bus
);

    localparam int N_SEL = 1 << SEL_W;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] first_q, first_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             cont_q, cont_d;
    logic             valid_q, valid_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_SEL-1:0] mask_in, mask_q;
    logic [SEL_W-1:0] sel_inc;
    idx_res_t         load_res, adv_res, wrap_res;
    logic             tmr_load, tmr_clear, tmr_run, tmr_expire;

`ifdef SCAN_SKIP_MASK_EN
    logic [N_SEL-1:0] mask_d;
    assign mask_in = bus.Skip_Mask;
`else
    assign mask_in = '0;
    assign mask_q  = '0;
`endif

    // Candidate indices for a fresh load, a forward advance, and a continuous restart.
    assign sel_inc  = sel_q + 1'b1;
    assign load_res = next_index(bus.First, bus.Last, mask_in);
    assign adv_res  = next_index(sel_inc, last_q, mask_q);
    assign wrap_res = next_index(first_q, last_q, mask_q);

    scan_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .load   (tmr_load),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .dwell  (bus.Dwell),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        first_d   = first_q;
        last_d    = last_q;
        cont_d    = cont_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        step_d    = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_run   = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
        mask_d    = mask_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Stop) begin
                    first_d = bus.First;
                    last_d  = bus.Last;
                    cont_d  = bus.Continuous;
`ifdef SCAN_SKIP_MASK_EN
                    mask_d  = mask_in;
`endif
                    // A fully masked range completes at once without ever asserting Sel_Valid.
                    if (load_res.found) begin
                        sel_d    = load_res.idx;
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                        step_d   = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    valid_d   = 1'b0;
                    busy_d    = 1'b0;
                    tmr_clear = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_run = 1'b1;
                    if (tmr_expire) begin
                        if ((sel_q != last_q) && adv_res.found) begin
                            sel_d  = adv_res.idx;
                            step_d = 1'b1;
                        end else if (cont_q && wrap_res.found) begin
                            sel_d  = wrap_res.idx;
                            step_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state is updated with non-blocking (<=) assignments only.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            cont_q  <= 1'b0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            last_q  <= last_d;
            cont_q  <= cont_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SCAN_SKIP_MASK_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

    assign bus.Sel       = sel_q;
    assign bus.Sel_Valid = valid_q;
    assign bus.Step      = step_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: a per-cycle expected trace is derived from the
// visit list of each scan and compared by an independent monitor on the falling edge.
module tb_decoder_scan_ctrl;

    typedef struct packed {
        logic       valid;
        logic [3:0] sel;
        logic       step;
        logic       busy;
        logic       done;
    } obs_t;

    logic Clk = 1'b0;
    logic Rst_n;

    decoder_scan_ctrl_if #(.SEL_W(4), .DWELL_W(8)) bus ();

    decoder_scan_ctrl #(.SEL_W(4), .DWELL_W(8)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   step_seen = 0;
    int   done_seen = 0;
    int   done_cyc = 0;
    obs_t exp_q[$];
    obs_t trace[$];
    obs_t idle_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.valid = bus.Sel_Valid;
        o.sel   = bus.Sel;
        o.step  = bus.Step;
        o.busy  = bus.Busy;
        o.done  = bus.Done;
        return o;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: one comparison per cycle, against the queued trace or the settled idle state.
    always @(negedge Clk) begin : monitor
        obs_t act, want;
        act = sample();
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("trace", 32'(act), 32'(want));
        end else begin
            check("idle", 32'(act), 32'(idle_exp));
        end
        if (bus.Step) step_seen++;
        if (bus.Done) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    function automatic int n_visits(input logic [3:0] first, input logic [3:0] last,
                                    input logic [15:0] mask);
        int n = 0;
        int idx = int'(first);
        for (int k = 0; k < 16; k++) begin
            if (!mask[idx]) n++;
            if (idx == int'(last)) break;
            idx = (idx + 1) % 16;
        end
        return n;
    endfunction

    // Reference: list the indices visited in scan order, expand each to dwell+1 cycles,
    // then end with Done (one-shot) or a stopped cycle; the trace ends in its settled idle state.
    task automatic build_trace(input logic [3:0] first, input logic [3:0] last, input int dwell,
                               input logic cont, input logic [15:0] mask, input int stop_at);
        int   vis[$];
        obs_t pass[$];
        obs_t o;
        int   idx;
        trace.delete();
        idx = int'(first);
        for (int k = 0; k < 16; k++) begin
            if (!mask[idx]) vis.push_back(idx);
            if (idx == int'(last)) break;
            idx = (idx + 1) % 16;
        end
        foreach (vis[v]) begin
            for (int c = 0; c <= dwell; c++) begin
                pass.push_back('{1'b1, 4'(vis[v]), (c == 0), 1'b1, 1'b0});
            end
        end
        if (vis.size() == 0) begin
            trace.push_back('{1'b0, idle_exp.sel, 1'b0, 1'b0, 1'b1});
        end else if (stop_at > 0 && (cont || stop_at <= pass.size())) begin
            for (int j = 0; j < stop_at; j++) trace.push_back(pass[j % pass.size()]);
            trace.push_back('{1'b0, trace[$].sel, 1'b0, 1'b0, 1'b0});
        end else begin
            foreach (pass[j]) trace.push_back(pass[j]);
            trace.push_back('{1'b0, 4'(vis[$]), 1'b0, 1'b0, 1'b1});
        end
        o = trace[$];
        o.done = 1'b0;
        trace.push_back(o);
    endtask

    task automatic run_scan(input logic [3:0] first, input logic [3:0] last, input int dwell,
                            input logic cont, input logic [15:0] mask, input int stop_at,
                            input bit poke);
        bus.First      = first;
        bus.Last       = last;
        bus.Dwell      = 8'(dwell);
        bus.Continuous = cont;
`ifdef SCAN_SKIP_MASK_EN
        bus.Skip_Mask  = mask;
`endif
        bus.Start = 1'b1;
        bus.Stop  = 1'b0;
        start_cyc = cyc;
        build_trace(first, last, dwell, cont, mask, stop_at);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        foreach (trace[i]) exp_q.push_back(trace[i]);
        idle_exp = trace[$];
        for (int j = 1; j <= trace.size(); j++) begin
            bus.Stop = (j == stop_at);
            if (poke && j == 2 && trace.size() > 1 && trace[1].busy) begin
                bus.Start      = 1'b1;
                bus.First      = 4'($urandom_range(0, 15));
                bus.Last       = 4'($urandom_range(0, 15));
                bus.Dwell      = 8'($urandom_range(0, 255));
                bus.Continuous = 1'($urandom_range(0, 1));
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge Clk);
            #1;
        end
        bus.Stop  = 1'b0;
        bus.Start = 1'b0;
    endtask

    task automatic start_stop_idle();
        bus.First = 4'($urandom_range(0, 15));
        bus.Last  = 4'($urandom_range(0, 15));
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        exp_q.push_back(idle_exp);
        exp_q.push_back(idle_exp);
        repeat (2) @(posedge Clk);
        #1;
        check("start_stop_busy", 32'(bus.Busy), 32'(0));
    endtask

    initial begin
        logic [3:0]  f, l;
        logic [15:0] m;
        logic        c;
        int          d, n, plen, stop_at;

        Rst_n          = 1'b0;
        bus.Start      = 1'b0;
        bus.Stop       = 1'b0;
        bus.Continuous = 1'b0;
        bus.First      = '0;
        bus.Last       = '0;
        bus.Dwell      = '0;
`ifdef SCAN_SKIP_MASK_EN
        bus.Skip_Mask  = '0;
`endif
        #1;
        check("reset_outputs", 32'(sample()), 32'(0));
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Full one-shot scan 1..15, five cycles per index; Done lands 76 cycles after
        // the cycle in which Start is driven.
        step_seen = 0;
        run_scan(4'd1, 4'd15, 4, 1'b0, 16'h0, 0, 1'b0);
        check("step_count", 32'(step_seen), 32'(15));
        check("done_latency", 32'(done_cyc - start_cyc), 32'(76));

        run_scan(4'd14, 4'd1, 0, 1'b0, 16'h0, 0, 1'b0);

        // Continuous 3..5 stopped while the second 4 is shown; no Done may appear.
        done_seen = 0;
        run_scan(4'd3, 4'd5, 1, 1'b1, 16'h0, 4, 1'b0);
        check("cont_stop_no_done", 32'(done_seen), 32'(0));

        start_stop_idle();
        run_scan(4'd6, 4'd6, 2, 1'b0, 16'h0, 0, 1'b1);
        run_scan(4'd9, 4'd9, 1, 1'b1, 16'h0, 5, 1'b0);
        run_scan(4'd2, 4'd7, 0, 1'b1, 16'h0, 9, 1'b0);

        // Asynchronous reset in the middle of a running scan.
        build_trace(4'd2, 4'd9, 3, 1'b1, 16'h0, 200);
        bus.First = 4'd2; bus.Last = 4'd9; bus.Dwell = 8'd3; bus.Continuous = 1'b1;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        foreach (trace[i]) exp_q.push_back(trace[i]);
        repeat (7) @(posedge Clk);
        #2;
        exp_q.delete();
        idle_exp = '0;
        Rst_n = 1'b0;
        #1;
        check("reset_mid_scan", 32'(sample()), 32'(0));
        @(posedge Clk);
        #3 Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        run_scan(4'd10, 4'd12, 1, 1'b0, 16'h0, 0, 1'b0);

`ifdef SCAN_SKIP_MASK_EN
        run_scan(4'd0, 4'd7, 0, 1'b0, 16'h00AA, 0, 1'b0);
        done_seen = 0;
        run_scan(4'd0, 4'd7, 0, 1'b0, 16'h00FF, 0, 1'b0);
        check("all_masked_done", 32'(done_seen), 32'(1));
`endif

        for (int it = 0; it < 40; it++) begin
            f = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            d = int'($urandom_range(0, 3));
            c = 1'($urandom_range(0, 1));
`ifdef SCAN_SKIP_MASK_EN
            m = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
`else
            m = 16'h0;
`endif
            n    = n_visits(f, l, m);
            plen = n * (d + 1);
            if (n == 0)      stop_at = 0;
            else if (c)      stop_at = int'($urandom_range(1, 3 * plen));
            else if ($urandom_range(0, 1) == 1) stop_at = int'($urandom_range(1, plen + 1));
            else             stop_at = 0;
            run_scan(f, l, d, c, m, stop_at, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) start_stop_idle();
        end

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
